// File: rtl/updown_counter_pkg.sv
// Shared counter definitions: mode/direction encodings and width helpers
// reused by every counter in the touch-control datapath.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int unsigned DEFAULT_MAX_MODULUS = 16;

  // Count width for a given largest modulus (never below one bit).
  function automatic int unsigned cnt_width(input int unsigned max_mod);
    return (max_mod <= 1) ? 1 : $clog2(max_mod);
  endfunction

  // Width needed to express the modulus itself, 0..max_mod inclusive.
  function automatic int unsigned mod_width(input int unsigned max_mod);
    return (max_mod < 1) ? 1 : $clog2(max_mod + 1);
  endfunction

endpackage

// File: rtl/updown_counter_if.sv
// Control/status bundle of updown_counter.
// OVF is present only when OVF_STICKY_EN is defined.
interface updown_counter_if
  import counter_pkg::*;
#(
  parameter int unsigned MAX_MODULUS = DEFAULT_MAX_MODULUS,
  localparam int unsigned N  = cnt_width(MAX_MODULUS),
  localparam int unsigned MW = mod_width(MAX_MODULUS)
);

  logic          ENABLE;
  logic          UP_DN;
  logic          MODE;
  logic          CLEAR;
  logic          LOAD;
  logic [N-1:0]  LOAD_VALUE;
  logic [MW-1:0] MOD_VALUE;
  logic [N-1:0]  COUNT;
  logic          TC;
`ifdef OVF_STICKY_EN
  logic          OVF;

  modport master (
    output ENABLE, UP_DN, MODE, CLEAR, LOAD, LOAD_VALUE, MOD_VALUE,
    input  COUNT, TC, OVF
  );

  modport slave (
    input  ENABLE, UP_DN, MODE, CLEAR, LOAD, LOAD_VALUE, MOD_VALUE,
    output COUNT, TC, OVF
  );
`else
  modport master (
    output ENABLE, UP_DN, MODE, CLEAR, LOAD, LOAD_VALUE, MOD_VALUE,
    input  COUNT, TC
  );

  modport slave (
    input  ENABLE, UP_DN, MODE, CLEAR, LOAD, LOAD_VALUE, MOD_VALUE,
    output COUNT, TC
  );
`endif

endinterface

// File: rtl/updown_counter_next.sv
// Combinational next-count and END compare for an up/down modulo counter.
// Expects an effective modulus me >= 1; works at N+1 bits so that
// me = 2^N does not alias when forming me-1 or count+1.
module updown_counter_next
  import counter_pkg::*;
#(
  parameter int unsigned MAX_MODULUS = DEFAULT_MAX_MODULUS,
  localparam int unsigned N  = cnt_width(MAX_MODULUS),
  localparam int unsigned MW = mod_width(MAX_MODULUS)
) (
  input  logic [N-1:0]  count,
  input  logic [MW-1:0] me,
  input  logic          up_dn,
  input  logic          mode,
  output logic [N-1:0]  next_count,
  output logic          at_end
);

  localparam int unsigned W = N + 1;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_x;
  logic [W-1:0] last_x;

  // Step one position in the selected direction, folding out-of-range
  // counts (left behind by a reduced modulus) back into range.
  always_comb begin
    count_x    = W'(count);
    last_x     = W'(me) - ONE;
    next_count = count;
    at_end     = 1'b0;
    if (up_dn == DIR_UP) begin
      at_end = (count_x == last_x);
      if (count_x > last_x) begin
        next_count = '0;
      end else if (count_x == last_x) begin
        next_count = (mode == MODE_SAT) ? count : '0;
      end else begin
        next_count = N'(count_x + ONE);
      end
    end else begin
      at_end = (count_x == '0);
      if (count_x > last_x) begin
        next_count = N'(last_x);
      end else if (count_x == '0) begin
        next_count = (mode == MODE_SAT) ? '0 : N'(last_x);
      end else begin
        next_count = N'(count_x - ONE);
      end
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down modulo counter with run-time modulus, synchronous clear/load,
// wrap or saturate mode and an enable-qualified combinational TC strobe.
// Define OVF_STICKY_EN to add the sticky OVF flag.
module updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned MAX_MODULUS = DEFAULT_MAX_MODULUS
) (
  input logic              CLK,
  input logic              RST_n,
  updown_counter_if.slave  bus
);

  localparam int unsigned N  = cnt_width(MAX_MODULUS);
  localparam int unsigned MW = mod_width(MAX_MODULUS);
  localparam int unsigned W  = N + 1;
  localparam logic [W-1:0] ONE = W'(1);

  logic [N-1:0]  count_q;
  logic [N-1:0]  next_count;
  logic [N-1:0]  load_count;
  logic [MW-1:0] me;
  logic [W-1:0]  last_x;
  logic          at_end;
  logic          tc;

  // Effective modulus (0 behaves as 1) and the clamped load value.
  always_comb begin
    me         = (bus.MOD_VALUE == '0) ? MW'(1) : bus.MOD_VALUE;
    last_x     = W'(me) - ONE;
    load_count = (W'(bus.LOAD_VALUE) > last_x) ? N'(last_x) : bus.LOAD_VALUE;
  end

  updown_counter_next #(
    .MAX_MODULUS (MAX_MODULUS)
  ) u_next (
    .count      (count_q),
    .me         (me),
    .up_dn      (bus.UP_DN),
    .mode       (bus.MODE),
    .next_count (next_count),
    .at_end     (at_end)
  );

  // Terminal count: only on a cycle that would actually step.
  always_comb begin
    tc = bus.ENABLE && !bus.CLEAR && !bus.LOAD && at_end;
  end

  // Count register with CLEAR > LOAD > ENABLE > hold priority.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      count_q <= '0;
    end else if (bus.CLEAR) begin
      count_q <= '0;
    end else if (bus.LOAD) begin
      count_q <= load_count;
    end else if (bus.ENABLE) begin
      count_q <= next_count;
    end
  end

  assign bus.COUNT = count_q;
  assign bus.TC    = tc;

`ifdef OVF_STICKY_EN
  logic ovf_q;

  // Sticky overflow. TC alone qualifies: in wrap mode every TC is a wrap,
  // in saturate mode every TC counts by definition.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ovf_q <= 1'b0;
    end else if (bus.CLEAR) begin
      ovf_q <= 1'b0;
    end else if (tc) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.OVF = ovf_q;
`endif

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down modulo counter with run-time modulus, synchronous load/clear and wrap or saturate mode. It is the general-purpose counting primitive for the touch-control datapath: debounce timers, scan-position indexing and cascaded prescalers. TC is a combinational, enable-qualified terminal-count strobe, so instances chain by wiring one TC to the next ENABLE.

## Interface
- MAX_MODULUS, 16, largest supported modulus; N = $clog2(MAX_MODULUS) count width, MW = $clog2(MAX_MODULUS+1) modulus width
- CLK  input  1  rising-edge clock
- RST_n  input  1  reset, asynchronous, active-low
- ENABLE  input  1  count step qualifier
- UP_DN  input  1  1 = count up, 0 = count down
- MODE  input  1  0 = wrap, 1 = saturate
- CLEAR  input  1  synchronous clear
- LOAD  input  1  synchronous load of LOAD_VALUE
- LOAD_VALUE  input  N  value to load
- MOD_VALUE  input  MW  run-time modulus M, legal range 0..MAX_MODULUS
- COUNT  output  N  registered count
- TC  output  1  terminal-count strobe, combinational

## Operation
- Effective modulus Me = M for M >= 1; M = 0 behaves as M = 1. END = Me-1 in up mode and 0 in down mode.
- Per-edge priority: CLEAR > LOAD > ENABLE > hold.
- CLEAR: COUNT <= 0, regardless of ENABLE.
- LOAD: COUNT <= min(LOAD_VALUE, Me-1). Out-of-range values clamp to Me-1.
- ENABLE in up mode:
  - If COUNT == Me-1, wrap mode goes to 0; saturate mode holds.
  - If COUNT > Me-1 (modulus was reduced), go to 0 in both modes.
  - Otherwise COUNT+1.
- ENABLE in down mode:
  - If COUNT == 0, wrap mode goes to Me-1; saturate mode holds at 0.
  - If COUNT > Me-1, go to Me-1 in both modes.
  - Otherwise COUNT-1.
- TC = ENABLE && !CLEAR && !LOAD && (COUNT == END). TC asserts in both modes, including while saturate mode holds at END.
- Me = 1: COUNT stays 0 and TC = ENABLE (when not cleared or loaded). Every enabled cycle is a terminal count.
- UP_DN, MODE and MOD_VALUE may change on any cycle. They are sampled at the same edge as ENABLE, with no pipeline.
- Arithmetic is done at N+1 bits internally so COUNT+1 cannot alias at MAX_MODULUS = 2^N.

## Timing
- Reset: COUNT = 0 asynchronously. TC follows its combinational definition (0 when ENABLE = 0). OVF = 0 when OVF_STICKY_EN is defined.
- COUNT latency: 1 cycle from a qualifying edge. TC is 0-latency: valid in the same cycle as ENABLE and COUNT.
- Cascading: a downstream counter whose ENABLE is driven by TC steps at the same edge on which the upstream counter wraps.
- RST_n asserted mid-count takes effect immediately. Counting resumes from 0 on the first rising edge after release that has ENABLE high.

## Configuration
- OVF_STICKY_EN defined:
  - Adds output OVF (1 bit, registered).
  - OVF is set at any edge where TC = 1 and the counter wraps (wrap mode), or where TC = 1 in saturate mode.
  - OVF is cleared only by CLEAR or reset. LOAD does not affect it.
- OVF_STICKY_EN undefined: the OVF port and its register are absent.

## Structure
- Shared package/header counter_pkg:
  - MODE_WRAP = 1'b0, MODE_SAT = 1'b1, DIR_DOWN = 1'b0, DIR_UP = 1'b1.
  - Width helper localparams, reused by other counters.
- One sub-module: updown_counter_next. It is a purely combinational next-state and END compare over COUNT, Me, UP_DN and MODE. It is reused by the future multi-channel scan counter.
- The top level holds the register, the priority logic and the optional OVF flop.

## Test plan
- Reset, M = 10, wrap, up, ENABLE = 1 for 12 cycles → COUNT 0..9,0,1. TC high only in the cycle COUNT = 9.
- M = 10, saturate, down, from LOAD 3 → COUNT 3,2,1,0,0,0. TC high in every cycle with COUNT = 0 and ENABLE = 1.
- LOAD_VALUE = 14 with M = 10 → COUNT = 9. CLEAR and LOAD in the same cycle → COUNT = 0, TC = 0.
- COUNT = 8, change M to 5: next up step → COUNT = 0; with a down step instead → COUNT = 4.
- M = 0 and M = 1 → COUNT stays 0, TC = ENABLE. MAX_MODULUS = 16, M = 16, up → wraps 15 → 0 without aliasing.
- Two instances cascaded (M = 4, M = 3), OVF_STICKY_EN defined → the second counter steps once per 4 enables, its OVF sets after enable 12, and CLEAR drops OVF to 0.
